// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: manual mode codes,
// burst FSM state encoding and burst direction values.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } usr_state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: two-state FSM with a length counter. Tells the datapath when
// to take a 1-bit shift and in which direction; reports busy and a one-cycle
// done pulse when the programmed number of shifts has completed.
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          burst_dir,
   input  logic [CW-1:0] burst_len,
   output logic          shift_en,
   output logic          shift_dir,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

   usr_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          done_q, done_d;
   logic [CW-1:0] len_sat;

   // Out-of-range lengths are clamped to a full-width burst.
   assign len_sat = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

   // Next-state logic: accept start only in IDLE, count shifts down in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               dir_d = burst_dir;
               cnt_d = len_sat;
               // A zero-length burst completes immediately without shifting.
               if (len_sat == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= DIR_RIGHT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   assign shift_en  = (state_q == ST_RUN);
   assign shift_dir = dir_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;

endmodule

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register: multi-bit shifts, rotates, load and
// clear under manual control, plus an autonomous 1-bit-per-cycle burst mode.
module param_universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = $clog2(WIDTH),
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             si_left,
   input  logic             si_right,
   input  logic             start,
   input  logic             burst_dir,
   input  logic [CW-1:0]    burst_len,
   output logic [WIDTH-1:0] q,
   output logic             so_lsb,
   output logic             so_msb,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             shift_en;
   logic             shift_dir;

   logic [2*WIDTH-1:0] shr_w, shl_w, ror_w, rol_w, asr_w;

   usr_burst_ctrl #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_burst_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .burst_dir (burst_dir),
      .burst_len (burst_len),
      .shift_en  (shift_en),
      .shift_dir (shift_dir),
      .busy      (busy),
      .done      (done)
   );

   // Multi-bit shift/rotate candidates: shift a double-width word so the
   // upper (or lower) half supplies the fill bits.
   always_comb begin
      shr_w = {{WIDTH{si_left}}, q_q} >> amt;
      shl_w = {q_q, {WIDTH{si_right}}} << amt;
      ror_w = {q_q, q_q} >> amt;
      rol_w = {q_q, q_q} << amt;
      asr_w = {{WIDTH{q_q[WIDTH-1]}}, q_q} >> amt;
   end

   // Next-state mux: burst shift beats a start request, which beats manual ops.
   always_comb begin
      q_d = q_q;
      if (shift_en) begin
         if (shift_dir == DIR_LEFT) begin
            q_d = {q_q[WIDTH-2:0], si_right};
         end else begin
            q_d = {si_left, q_q[WIDTH-1:1]};
         end
      end else if (!start && en) begin
         case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = shr_w[WIDTH-1:0];
            MODE_SHL:  q_d = shl_w[2*WIDTH-1:WIDTH];
            MODE_LOAD: q_d = data_in;
            MODE_ROR:  q_d = ror_w[WIDTH-1:0];
            MODE_ROL:  q_d = rol_w[2*WIDTH-1:WIDTH];
            MODE_ASR:  q_d = asr_w[WIDTH-1:0];
            MODE_CLR:  q_d = '0;
            default:   q_d = q_q;
         endcase
      end
   end

   // Data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign so_lsb = q_q[0];
   assign so_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Scoreboard bench for param_universal_shift_reg (WIDTH=8). The driver updates
// an arithmetic reference model each cycle and queues the expected outputs;
// the monitor pops and compares after every rising edge.
module tb_param_universal_shift_reg;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [2:0] amt = 3'd0;
   logic [7:0] data_in = 8'h00;
   logic       si_left = 1'b0;
   logic       si_right = 1'b0;
   logic       start = 1'b0;
   logic       burst_dir = 1'b0;
   logic [3:0] burst_len = 4'd0;
   logic [7:0] q;
   logic       so_lsb, so_msb, busy, done;

   typedef struct {
      bit [7:0] q;
      bit       busy;
      bit       done;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state
   int m_q = 0;
   int m_rem = 0;
   bit m_dir = 0;
   bit m_done = 0;

   param_universal_shift_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .amt       (amt),
      .data_in   (data_in),
      .si_left   (si_left),
      .si_right  (si_right),
      .start     (start),
      .burst_dir (burst_dir),
      .burst_len (burst_len),
      .q         (q),
      .so_lsb    (so_lsb),
      .so_msb    (so_msb),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Advance the model by one edge using the inputs currently driven.
   function automatic void model_step();
      int k = int'(amt);
      int s;
      int len;
      m_done = 0;
      if (rst) begin
         m_q = 0;
         m_rem = 0;
      end else if (m_rem > 0) begin
         if (m_dir) m_q = ((m_q << 1) | int'(si_right)) & 255;
         else       m_q = (m_q >> 1) | (int'(si_left) << 7);
         m_rem--;
         if (m_rem == 0) m_done = 1;
      end else if (start) begin
         len = (int'(burst_len) > W) ? W : int'(burst_len);
         if (len == 0) m_done = 1;
         else begin
            m_rem = len;
            m_dir = burst_dir;
         end
      end else if (en) begin
         case (mode)
            3'b001: m_q = (m_q >> k) | (si_left ? (((1 << k) - 1) << (W - k)) : 0);
            3'b010: m_q = ((m_q << k) | (si_right ? ((1 << k) - 1) : 0)) & 255;
            3'b011: m_q = int'(data_in);
            3'b100: m_q = ((m_q >> k) | (m_q << (W - k))) & 255;
            3'b101: m_q = ((m_q << k) | (m_q >> (W - k))) & 255;
            3'b110: begin
               s = (m_q >= 128) ? m_q - 256 : m_q;
               m_q = (s >>> k) & 255;
            end
            3'b111: m_q = 0;
            default: ;
         endcase
      end
   endfunction

   // One cycle: queue the expected post-edge outputs, then let the edge pass.
   task automatic step();
      exp_t e;
      model_step();
      e.q = m_q[7:0];
      e.busy = (m_rem > 0);
      e.done = m_done;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; en = 0; start = 0;
   endtask

   task automatic manual(input bit [2:0] m, input int k, input bit [7:0] d,
                         input bit sl, input bit sr);
      rst = 0; start = 0; en = 1; mode = m; amt = k[2:0]; data_in = d;
      si_left = sl; si_right = sr;
      step();
      en = 0;
   endtask

   task automatic burst_start(input bit dir, input int len, input bit sl, input bit sr);
      rst = 0; en = 0; start = 1; burst_dir = dir; burst_len = len[3:0];
      si_left = sl; si_right = sr;
      step();
      start = 0;
   endtask

   // Full-length burst to the left filling ones; checks busy span and result.
   task automatic full_burst(input int len, input string tag);
      int nbusy = 0;
      manual(3'b111, 0, 8'h00, 0, 0);
      burst_start(1, len, 0, 1);
      for (int i = 0; i < 20 && busy; i++) begin
         nbusy++;
         step();
      end
      check({tag, "_busy_cycles"}, nbusy, 8);
      check({tag, "_q"}, int'(q), 8'hFF);
      check({tag, "_done"}, int'(done), 1);
      step();
   endtask

   // Monitor: compare every edge's outputs against the queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_q", int'(q), int'(e.q));
         check("sb_busy", int'(busy), int'(e.busy));
         check("sb_done", int'(done), int'(e.done));
         check("sb_so_lsb", int'(so_lsb), int'(e.q[0]));
         check("sb_so_msb", int'(so_msb), int'(e.q[7]));
      end
   end

   initial begin
      int nbusy;
      int ndone;
      bit [3:0] lsb_seq;

      // Reset and load
      rst = 1; step(); step();
      check("rst_q", int'(q), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      idle();
      manual(3'b011, 0, 8'hA5, 0, 0);
      check("load_a5", int'(q), 8'hA5);

      // Multi-bit shifts and rotates
      manual(3'b001, 3, 8'h00, 1, 0);
      check("shr3", int'(q), 8'hF4);
      manual(3'b011, 0, 8'hA5, 0, 0);
      manual(3'b010, 2, 8'h00, 0, 0);
      check("shl2", int'(q), 8'h94);
      manual(3'b011, 0, 8'h81, 0, 0);
      manual(3'b110, 3, 8'h00, 0, 0);
      check("asr3", int'(q), 8'hF0);
      manual(3'b011, 0, 8'h81, 0, 0);
      manual(3'b100, 1, 8'h00, 0, 0);
      check("ror1", int'(q), 8'hC0);
      manual(3'b101, 4, 8'h00, 0, 0);
      check("rol4", int'(q), 8'h0C);
      manual(3'b001, 0, 8'h00, 1, 1);
      check("shr0_nomove", int'(q), 8'h0C);

      // Burst right of 0xB4 by 4
      manual(3'b011, 0, 8'hB4, 0, 0);
      burst_start(0, 4, 0, 0);
      nbusy = 0;
      lsb_seq = 4'b0000;
      for (int i = 0; i < 20 && busy; i++) begin
         if (nbusy < 4) lsb_seq[3 - nbusy] = so_lsb;
         nbusy++;
         step();
      end
      check("burst4_busy_cycles", nbusy, 4);
      check("burst4_q", int'(q), 8'h0B);
      check("burst4_done", int'(done), 1);
      check("burst4_lsb_seq", int'(lsb_seq), 4'b0010);
      step();
      check("burst4_done_single", int'(done), 0);

      // Interference while running
      manual(3'b011, 0, 8'hB4, 0, 0);
      burst_start(0, 4, 0, 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         ndone += int'(done);
         if (busy) begin
            en = 1; mode = 3'b111; start = 1; burst_len = 4'd3; data_in = 8'h5A;
         end else begin
            idle();
         end
         si_left = 0;
         step();
      end
      idle();
      check("intf_done_count", ndone, 1);
      check("intf_q", int'(q), 8'h0B);
      check("intf_busy", int'(busy), 0);

      // Zero-length burst
      manual(3'b011, 0, 8'h3C, 0, 0);
      burst_start(0, 0, 1, 1);
      check("len0_done", int'(done), 1);
      check("len0_busy", int'(busy), 0);
      check("len0_q", int'(q), 8'h3C);
      step();
      check("len0_done_single", int'(done), 0);

      // Full length and saturated length
      full_burst(8, "len8");
      full_burst(9, "len9");

      // Reset mid-burst
      manual(3'b011, 0, 8'hFF, 0, 0);
      burst_start(0, 6, 0, 0);
      step(); step();
      check("abort_pre_q", int'(q), 8'h3F);
      rst = 1; step(); rst = 0;
      check("abort_q", int'(q), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      step();
      check("abort_no_done", int'(done), 0);
      burst_start(1, 2, 0, 1);
      check("restart_busy", int'(busy), 1);
      step(); step();
      check("restart_q", int'(q), 8'h03);
      check("restart_done", int'(done), 1);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         start = ($urandom_range(0, 7) == 0);
         en = $urandom_range(0, 1);
         mode = 3'($urandom_range(0, 7));
         amt = 3'($urandom_range(0, 7));
         data_in = 8'($urandom);
         si_left = $urandom_range(0, 1);
         si_right = $urandom_range(0, 1);
         burst_dir = $urandom_range(0, 1);
         burst_len = 4'($urandom_range(0, 9));
         step();
      end
      idle();
      step();
      @(posedge clk);
      #2;
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
